uart_loopback_checker: RTL and testbench

Self-test initiator for the far end of the UART loopback path. It drives a known byte sequence out on its own TX line and receives the echoed bytes on its RX line. Each echo is compared against the byte sent, and errors and timeouts are counted. It works stop-and-wait: one byte is in flight at a time. It holds its own 8N1 serializer and deserializer, and sits at board top or in a bench opposite the loopback design.

---
 rtl/uart_loopback_checker.sv | 229 ++++++++++++++++++++++
 tb/tb_uart_loopback_checker.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_loopback_checker.sv
`timescale 1ns/1ps
// Stop-and-wait UART loopback self-test initiator with its own 8N1 serializer/deserializer.
// Define UART_CHK_PRBS_EN to replace the incrementing pattern with an 8-bit LFSR.
module uart_loopback_checker #(
  parameter int         CLK_FREQ     = 50_000_000,
  parameter int         UART_BPS     = 115200,
  parameter int         NUM_BYTES    = 16,
  parameter logic [7:0] SEED         = 8'h00,
  parameter int         TIMEOUT_BITS = 40
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       start,
  input  logic       uart_rxd,
  output logic       uart_txd,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_cnt,
  output logic       timeout_seen
);
  localparam int BPS_CNT  = CLK_FREQ / UART_BPS;
  localparam int HALF_CNT = BPS_CNT / 2;
  localparam int TO_CNT   = TIMEOUT_BITS * BPS_CNT;
  localparam int CNT_MAX  = (TO_CNT > BPS_CNT) ? TO_CNT : BPS_CNT;
  localparam int CW       = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] BIT_LAST  = CW'(BPS_CNT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CNT - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TO_CNT - 1);
  localparam logic [7:0]    K_LAST    = 8'(NUM_BYTES - 1);

`ifdef UART_CHK_PRBS_EN
  // x^8+x^6+x^5+x^4+1, shifting left; an all-zero state would lock up, so seed 0 becomes 1.
  localparam logic [7:0] PAT_INIT = (SEED == 8'h00) ? 8'h01 : SEED;
  function automatic logic [7:0] pat_step(input logic [7:0] p);
    return {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
  endfunction
`else
  localparam logic [7:0] PAT_INIT = SEED;
  function automatic logic [7:0] pat_step(input logic [7:0] p);
    return p + 8'd1;
  endfunction
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SEND, S_WAIT_ECHO, S_CHECK, S_FINISH
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    k_q, k_d;
  logic [7:0]    pat_q, pat_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_stop_q, rx_stop_d;
  logic          rx_active_q, rx_active_d;
  logic          skip_q, skip_d;
  logic          txd_q, txd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [7:0]    err_q, err_d;
  logic          timeout_q, timeout_d;
  logic [2:0]    rx_sync_q;

  logic       rx_s, rx_fall;
  logic [7:0] err_inc;

  assign rx_s    = rx_sync_q[1];
  assign rx_fall = rx_sync_q[2] & ~rx_sync_q[1];
  assign err_inc = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

  always_comb begin
    // NOTE: every _d defaults to its hold value first, so no branch can leave a latch behind.
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    k_d         = k_q;
    pat_d       = pat_q;
    tx_byte_d   = tx_byte_q;
    rx_byte_d   = rx_byte_q;
    rx_stop_d   = rx_stop_q;
    rx_active_d = rx_active_q;
    skip_d      = skip_q;
    txd_d       = txd_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_d       = err_q;
    timeout_d   = timeout_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d     = 8'd0;
          timeout_d = 1'b0;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          busy_d    = 1'b1;
          k_d       = 8'd0;
          pat_d     = PAT_INIT;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        tx_byte_d = pat_q;
        txd_d     = 1'b0;
        cnt_d     = '0;
        bit_d     = 4'd0;
        state_d   = S_SEND;
      end
      S_SEND: begin
        // txd_q already holds bit_q; at the bit boundary load the next one.
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          bit_d = bit_q + 4'd1;
          if (bit_q == 4'd9) begin
            txd_d       = 1'b1;
            bit_d       = 4'd0;
            rx_active_d = 1'b0;
            skip_d      = 1'b0;
            state_d     = S_WAIT_ECHO;
          end else if (bit_q == 4'd8) begin
            txd_d = 1'b1;
          end else begin
            txd_d = tx_byte_q[bit_q[2:0]];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_ECHO: begin
        if (!rx_active_q) begin
          if (rx_fall) begin
            rx_active_d = 1'b1;
            cnt_d       = '0;
            bit_d       = 4'd0;
          end else if (cnt_q == TO_LAST) begin
            err_d     = err_inc;
            timeout_d = 1'b1;
            skip_d    = 1'b1;
            state_d   = S_CHECK;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (cnt_q == ((bit_q == 4'd0) ? HALF_LAST : BIT_LAST)) begin
          // Sample 0 is the start bit's mid-point, 1..8 are data, 9 is the stop bit.
          cnt_d = '0;
          bit_d = bit_q + 4'd1;
          if (bit_q == 4'd9) begin
            rx_stop_d = rx_s;
            state_d   = S_CHECK;
          end else if (bit_q != 4'd0) begin
            rx_byte_d = {rx_s, rx_byte_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CHECK: begin
        if (!skip_q && ((rx_byte_q != tx_byte_q) || !rx_stop_q)) begin
          err_d = err_inc;
        end
        skip_d  = 1'b0;
        k_d     = k_q + 8'd1;
        pat_d   = pat_step(pat_q);
        state_d = (k_q == K_LAST) ? S_FINISH : S_LOAD;
      end
      S_FINISH: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (err_q == 8'd0);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments, so every flop samples pre-edge values regardless of order.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= 4'd0;
      k_q         <= 8'd0;
      pat_q       <= 8'd0;
      tx_byte_q   <= 8'd0;
      rx_byte_q   <= 8'd0;
      rx_stop_q   <= 1'b0;
      rx_active_q <= 1'b0;
      skip_q      <= 1'b0;
      txd_q       <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= 8'd0;
      timeout_q   <= 1'b0;
      rx_sync_q   <= 3'b111;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      k_q         <= k_d;
      pat_q       <= pat_d;
      tx_byte_q   <= tx_byte_d;
      rx_byte_q   <= rx_byte_d;
      rx_stop_q   <= rx_stop_d;
      rx_active_q <= rx_active_d;
      skip_q      <= skip_d;
      txd_q       <= txd_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      timeout_q   <= timeout_d;
      rx_sync_q   <= {rx_sync_q[1:0], uart_rxd};
    end
  end

  assign uart_txd     = txd_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign err_cnt      = err_q;
  assign timeout_seen = timeout_q;

endmodule

// File: tb/tb_uart_loopback_checker.sv
`timescale 1ns/1ps
// Bench for uart_loopback_checker: decodes its TX line, echoes bytes back (clean, silent or
// corrupted) and checks outputs against a byte-level model of the test run.
module tb_uart_loopback_checker;
  localparam int         B    = 10;   // cycles per bit: 1000 / 100
  localparam int         HALF = B / 2;
  localparam int         NB   = 8;
  localparam int         TOB  = 40;
  localparam int         TO   = TOB * B;
  localparam logic [7:0] SEED = 8'hFC;
  localparam int         BUDGET = 8000;

  typedef enum int {M_CLEAN, M_SILENT, M_CORRUPT} mode_e;
  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         due;
  } echo_t;

  logic       clk = 1'b0;
  logic       rst_n, start, rxd_drv;
  logic       uart_txd, busy, done, pass, timeout_seen;
  logic [7:0] err_cnt;

  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc = 0;
  int    tx_cnt = 0;
  int    last_stop_end = 0;
  bit    chk_en = 1'b0;
  mode_e run_mode = M_CLEAN;
  echo_t echo_q[$];
  logic [7:0] tx_log [0:255];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_loopback_checker #(
    .CLK_FREQ(1000), .UART_BPS(100), .NUM_BYTES(NB), .SEED(SEED), .TIMEOUT_BITS(TOB)
  ) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .start(start), .uart_rxd(rxd_drv),
    .uart_txd(uart_txd), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .timeout_seen(timeout_seen)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pattern byte k of a run, straight from the pattern rule.
  function automatic logic [7:0] exp_byte(input int k);
    logic [7:0] p;
`ifdef UART_CHK_PRBS_EN
    p = (SEED == 8'h00) ? 8'h01 : SEED;
    for (int i = 0; i < k; i++) p = {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
`else
    p = SEED + 8'(k);
`endif
    return p;
  endfunction

  function automatic int exp_err(input mode_e m);
    case (m)
      M_SILENT:  return (NB > 255) ? 255 : NB;
      M_CORRUPT: return 2;
      default:   return 0;
    endcase
  endfunction

  // TX decoder: mid-bit sampling of each frame, then schedule its echo.
  initial begin : tx_monitor
    logic prev, ok, stb, stopb;
    logic [7:0] b, data;
    int c0, idx;
    echo_t e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b1;
      end else if (prev && !uart_txd) begin
        c0 = cyc; ok = 1'b1; b = 8'd0; stb = 1'b1; stopb = 1'b0;
        for (int k = 1; k <= 9 * B + HALF; k++) begin
          @(negedge clk);
          if (!rst_n) begin
            ok = 1'b0;
            break;
          end
          if (k >= HALF && (k - HALF) % B == 0) begin
            idx = (k - HALF) / B;
            if (idx == 0)      stb = uart_txd;
            else if (idx <= 8) b[idx-1] = uart_txd;
            else               stopb = uart_txd;
          end
        end
        if (ok) begin
          check("tx_start_bit", stb, 1'b0);
          check("tx_stop_bit", stopb, 1'b1);
          check("tx_byte", b, exp_byte(tx_cnt));
          tx_log[tx_cnt % 256] = b;
          data   = b;
          e.stop = 1'b1;
          if (run_mode == M_CORRUPT && tx_cnt == 3) data = data ^ 8'h01;
          if (run_mode == M_CORRUPT && tx_cnt == 7) begin
            data   = data ^ 8'h80;
            e.stop = 1'b0;
          end
          e.data        = data;
          e.due         = c0 + 10 * B + int'($urandom_range(1, 15));
          last_stop_end = c0 + 10 * B;
          echo_q.push_back(e);
          tx_cnt++;
        end
        prev = ok ? uart_txd : 1'b1;
      end else begin
        prev = uart_txd;
      end
    end
  end

  // Far-end echo: replays each scheduled byte on the RX line unless the line is silent.
  initial begin : echo_gen
    echo_t e;
    logic [9:0] frame;
    forever begin
      @(negedge clk);
      if (echo_q.size() != 0 && cyc >= echo_q[0].due) begin
        e = echo_q.pop_front();
        if (run_mode != M_SILENT) begin
          frame = {e.stop, e.data, 1'b0};
          for (int i = 0; i < 10; i++) begin
            rxd_drv = frame[i];
            repeat (B) @(negedge clk);
          end
          rxd_drv = 1'b1;
        end
      end
    end
  end

  // Every-cycle consistency against the run model.
  initial begin : cycle_checker
    logic [7:0] prev_err;
    prev_err = 8'd0;
    forever begin
      @(negedge clk);
      if (chk_en && rst_n) begin
        check("busy_done_exclusive", busy & done, 1'b0);
        if (done) check("pass_vs_err", pass, err_cnt == 8'd0);
        check("timeout_flag", timeout_seen, (run_mode == M_SILENT) && (err_cnt != 8'd0));
        check("err_within_bound", int'(err_cnt) <= exp_err(run_mode), 1'b1);
        if (!busy) check("txd_idle_high", uart_txd, 1'b1);
        if (err_cnt != prev_err && err_cnt != 8'd0 && run_mode == M_SILENT)
          check("timeout_delay", cyc - last_stop_end, TO);
      end
      prev_err = err_cnt;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_run(input mode_e m);
    @(negedge clk);
    tx_cnt = 0;
    start  = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    run_mode = m;
    check("busy_after_start", busy, 1'b1);
    check("done_clear_on_start", done, 1'b0);
    check("err_clear_on_start", err_cnt, 8'd0);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_within_budget", done, 1'b1);
  endtask

  task automatic check_end(input mode_e m);
    check("end_done", done, 1'b1);
    check("end_busy", busy, 1'b0);
    check("end_err_cnt", err_cnt, exp_err(m));
    check("end_pass", pass, exp_err(m) == 0);
    check("end_timeout_seen", timeout_seen, m == M_SILENT);
    check("end_tx_count", tx_cnt, NB);
  endtask

  initial begin : main
    int n;
    rst_n = 1'b0; start = 1'b0; rxd_drv = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_txd", uart_txd, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_err_cnt", err_cnt, 8'd0);
    check("rst_timeout_seen", timeout_seen, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;

    // Clean echo: full pass, and pin the observed sequence by hand.
    start_run(M_CLEAN);
    wait_done(BUDGET);
    check_end(M_CLEAN);
`ifdef UART_CHK_PRBS_EN
    check("pin_byte0", tx_log[0], 8'hFC);
    check("pin_byte1", tx_log[1], 8'hF8);
    check("pin_byte2", tx_log[2], 8'hF0);
`else
    check("pin_byte0", tx_log[0], 8'hFC);
    check("pin_byte3", tx_log[3], 8'hFF);
    check("pin_byte4_wrap", tx_log[4], 8'h00);
`endif

    // Silent line: every byte times out.
    start_run(M_SILENT);
    wait_done(BUDGET);
    check_end(M_SILENT);

    // Byte 3 data flipped; byte 7 data flipped and stop bit 0 counts once.
    start_run(M_CORRUPT);
    wait_done(BUDGET);
    check_end(M_CORRUPT);

    // Start pulses while busy, held through the FINISH cycle: no restart.
    start_run(M_CORRUPT);
    n = 0;
    while (n < BUDGET) begin
      @(negedge clk);
      n++;
      if (done) break;
      start = (tx_cnt >= NB) ? 1'b1 : ($urandom_range(0, 199) == 0);
    end
    start = 1'b0;
    check("done_after_pulses", done, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_err_cnt", err_cnt, 8'd2);
      check("hold_done", done, 1'b1);
      check("hold_busy", busy, 1'b0);
    end
    check("no_restart_tx_count", tx_cnt, NB);

    // Start after done restarts and clears the count.
    start_run(M_CLEAN);
    wait_done(BUDGET);
    check_end(M_CLEAN);

    // Reset in the middle of a start bit.
    start_run(M_CLEAN);
    n = 0;
    while (uart_txd && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("txd_low_before_reset", uart_txd, 1'b0);
    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("midrst_txd", uart_txd, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_err_cnt", err_cnt, 8'd0);
    repeat (2) @(negedge clk);
    echo_q.delete();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("post_rst_txd_idle", uart_txd, 1'b1);
    start_run(M_CLEAN);
    wait_done(BUDGET);
    check_end(M_CLEAN);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
